keypad_param_entry: RTL and testbench
=====================================

Name: keypad_param_entry

Overview:
Parametrised successor to the irrigation keypad threshold-entry logic. Scans a 4x4 active-low row/column keypad pattern and debounces it into single key events. A start / select-category / enter-digits / accept-or-cancel sequence runs through a state machine and commits decimal values into an internal bank of NUM_CAT threshold registers. It sits between the keypad pins and the irrigation controller, which reads param_bank and reacts to the update pulses.

Parameters:
NUM_CAT, 8, number of parameter categories (1..9), selected by digit keys 1..NUM_CAT
VAL_W, 10, width of each stored value; MAX_VAL = 2^VAL_W-1
MAX_DIGITS, 4, maximum decimal digits per entry (1..4)
DEBOUNCE_CYC, 2, consecutive identical samples required before a key event (>=1)
TIMEOUT_CYC, 1000, idle cycles in SEL_CAT/ENTRY before abort; 0 disables timeout
INIT_VALS, all zeros, NUM_CAT*VAL_W-bit packed reset contents; slice k-1 = category k

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = keypad processed; 0 = forced to IDLE, events ignored
keypad_row  in  4  active-low row lines
keypad_col  in  4  active-low column lines
busy  out  1  1 in SEL_CAT or ENTRY
category  out  4  selected category 1..NUM_CAT; 0 = none
entry_value  out  VAL_W  live accumulator during entry
digit_count  out  3  digits currently entered
new_value  out  VAL_W  last committed value
update_pulse  out  NUM_CAT  one-cycle one-hot pulse, bit k-1 = category k written
updated  out  1  one-cycle pulse on any commit
error  out  1  one-cycle pulse on a rejected key
timeout  out  1  one-cycle pulse on timeout abort
param_bank  out  NUM_CAT*VAL_W  registered parameter bank

Behaviour:
- Reset (async, reset=0): state IDLE; category, entry_value, digit_count and new_value = 0; all pulses = 0; param_bank = INIT_VALS; debounce logic cleared.
- Key decode: a valid press is exactly one row bit 0 and exactly one col bit 0.
  - Row0: 1, 2, 3, START.
  - Row1: 4, 5, 6, BACKSPACE.
  - Row2: 7, 8, 9, (unused).
  - Row3: 0, ACCEPT, CANCEL, (unused).
  - Col bit0 = column 0, so row 1011 / col 1110 = '7'.
- Release: row==1111 or col==1111. Any other pattern is invalid: it clears the debounce counter and does not count as a release.
- Debounce: key_event fires once, for one cycle, when the same code has been sampled at DEBOUNCE_CYC consecutive edges. No further event occurs until a release has been sampled for at least 1 cycle. Unused keys produce no event.
- The FSM acts on key_event; registered outputs change at the following edge.
- States and transitions:
  - IDLE: START -> SEL_CAT; clears category, entry_value and digit_count. All other keys are ignored and raise no error.
  - SEL_CAT:
    - Digit d with 1<=d<=NUM_CAT: category=d -> ENTRY.
    - Digit 0 or d>NUM_CAT: error pulse, stay.
    - BACKSPACE or CANCEL -> IDLE.
    - START restarts SEL_CAT.
    - ACCEPT: error pulse.
  - ENTRY:
    - Digit: tmp = entry_value*10 + d, computed in VAL_W+4 bits.
      - digit_count==MAX_DIGITS or tmp>MAX_VAL: error pulse, entry_value unchanged.
      - Otherwise entry_value=tmp, digit_count+1.
    - BACKSPACE: entry_value = entry_value/10 and digit_count-1; no-op when digit_count=0.
    - ACCEPT with digit_count=0: error pulse, stay.
    - ACCEPT with digit_count>0 -> COMMIT.
    - CANCEL -> IDLE with no write.
    - START -> SEL_CAT, clearing entry state.
  - COMMIT (exactly one cycle): slice category-1 of param_bank = entry_value; new_value = entry_value; update_pulse[category-1]=1; updated=1 -> IDLE. category is retained until the next START.
- Timeout: a counter is cleared on every key_event and on every state change. When it reaches TIMEOUT_CYC in SEL_CAT or ENTRY: timeout pulse -> IDLE, no write.
- enable=0: next state IDLE; pulses 0 except that a same-cycle COMMIT still completes; param_bank is preserved.
- Simultaneous events: reset overrides everything. enable=0 overrides key_event. A timeout and a key_event in the same cycle: key_event wins and the counter clears.

Test Plan:
- Defaults, DEBOUNCE_CYC=2, keys held 4 cycles with 4-cycle releases. START, 2, 7, BACKSPACE, 7, ACCEPT -> param_bank slice1=7; update_pulse=8'b0000_0010 for 1 cycle; updated 1 cycle; new_value=7; category=2.
- START, 3, 7, 8, 9, ACCEPT -> slice2=789, update_pulse=8'b0000_0100; all other slices unchanged.
- START, 1, 1, 0, 2, 4 -> the '4' gives 1024 > 1023: error pulse, entry_value stays 102. Then ACCEPT -> slice0=102.
- START, 9 (NUM_CAT=8) -> error pulse, state stays SEL_CAT, category=0. Then CANCEL -> busy=0, bank unchanged.
- TIMEOUT_CYC=50: START, 6, 5, then no keys -> timeout pulse exactly 50 cycles after the '5' event; busy=0; slice5 unchanged. Separately, a key held only 1 cycle -> no event.
- Assert reset=0 asynchronously mid-ENTRY -> all outputs take their reset values before the next clk edge; param_bank = INIT_VALS. Also, two keys pressed at once (row 1100) -> no event.

Source files
------------

// File: rtl/keypad_param_entry_if.sv
// Keypad pins in, entry status and parameter bank out; the design drives the slave side.
interface keypad_param_entry_if #(
    parameter int NUM_CAT = 8,
    parameter int VAL_W   = 10
);
    logic                     enable;
    logic [3:0]               keypad_row;
    logic [3:0]               keypad_col;
    logic                     busy;
    logic [3:0]               category;
    logic [VAL_W-1:0]         entry_value;
    logic [2:0]               digit_count;
    logic [VAL_W-1:0]         new_value;
    logic [NUM_CAT-1:0]       update_pulse;
    logic                     updated;
    logic                     error;
    logic                     timeout;
    logic [NUM_CAT*VAL_W-1:0] param_bank;

    modport master (
        output enable, keypad_row, keypad_col,
        input  busy, category, entry_value, digit_count, new_value,
               update_pulse, updated, error, timeout, param_bank
    );

    modport slave (
        input  enable, keypad_row, keypad_col,
        output busy, category, entry_value, digit_count, new_value,
               update_pulse, updated, error, timeout, param_bank
    );
endinterface

// File: rtl/keypad_param_entry.sv
// 4x4 keypad debouncer + category/value entry FSM committing decimal values into a parameter bank.
// Key event DEBOUNCE_CYC edges after a stable press, FSM outputs one edge later; no backpressure, all pulses one cycle.
module keypad_param_entry #(
    parameter int                         NUM_CAT      = 8,
    parameter int                         VAL_W        = 10,
    parameter int                         MAX_DIGITS   = 4,
    parameter int                         DEBOUNCE_CYC = 2,
    parameter int                         TIMEOUT_CYC  = 1000,
    parameter logic [NUM_CAT*VAL_W-1:0]   INIT_VALS    = '0
) (
    input  logic                clk,
    input  logic                reset,
    keypad_param_entry_if.slave kp
);
    localparam logic [3:0] K_START  = 4'd10;
    localparam logic [3:0] K_BKSP   = 4'd11;
    localparam logic [3:0] K_ACCEPT = 4'd12;
    localparam logic [3:0] K_CANCEL = 4'd13;
    localparam logic [3:0] K_NONE   = 4'd15;
    localparam int MAX_VAL = (1 << VAL_W) - 1;
    localparam int TMP_W   = VAL_W + 4;
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam int TO_W    = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEL_CAT, ENTRY, COMMIT} state_t;

    logic [1:0] row_idx, col_idx;
    logic       row_ok, col_ok, is_release, is_press;
    logic [3:0] scan_code;

    always_comb begin
        row_ok    = 1'b1;
        col_ok    = 1'b1;
        row_idx   = 2'd0;
        col_idx   = 2'd0;
        scan_code = K_NONE;
        case (kp.keypad_row)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
        case (kp.keypad_col)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
        case ({row_idx, col_idx})
            4'h0: scan_code = 4'd1;
            4'h1: scan_code = 4'd2;
            4'h2: scan_code = 4'd3;
            4'h3: scan_code = K_START;
            4'h4: scan_code = 4'd4;
            4'h5: scan_code = 4'd5;
            4'h6: scan_code = 4'd6;
            4'h7: scan_code = K_BKSP;
            4'h8: scan_code = 4'd7;
            4'h9: scan_code = 4'd8;
            4'hA: scan_code = 4'd9;
            4'hC: scan_code = 4'd0;
            4'hD: scan_code = K_ACCEPT;
            4'hE: scan_code = K_CANCEL;
            default: scan_code = K_NONE;
        endcase
    end

    assign is_release = (kp.keypad_row == 4'hF) || (kp.keypad_col == 4'hF);
    assign is_press   = row_ok && col_ok;

    // Debounce: armed re-opens only after a sampled release, so a held key yields one event.
    logic [3:0]      last_code, key_code;
    logic [DB_W-1:0] db_cnt, db_cnt_n;
    logic            armed, key_event, fire;

    always_comb begin
        db_cnt_n = DB_W'(1);
        if (scan_code == last_code && db_cnt != '0)
            db_cnt_n = (db_cnt == DB_W'(DEBOUNCE_CYC)) ? db_cnt : db_cnt + DB_W'(1);
        fire = is_press && armed && (scan_code != K_NONE) && (db_cnt_n == DB_W'(DEBOUNCE_CYC));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_code <= K_NONE;
            key_code  <= K_NONE;
            db_cnt    <= '0;
            armed     <= 1'b1;
            key_event <= 1'b0;
        end else begin
            key_event <= fire;
            if (fire) begin
                key_code <= scan_code;
                armed    <= 1'b0;
            end
            if (is_release) begin
                db_cnt <= '0;
                armed  <= 1'b1;
            end else if (!is_press) begin
                db_cnt <= '0;
            end else begin
                db_cnt    <= db_cnt_n;
                last_code <= scan_code;
            end
        end
    end

    state_t                   state, state_n;
    logic [3:0]               category, category_n;
    logic [VAL_W-1:0]         entry_value, entry_n, new_value, new_value_n;
    logic [2:0]               digit_count, dcount_n;
    logic [NUM_CAT-1:0]       update_pulse, update_n;
    logic                     updated, updated_n, error, error_n, timeout, timeout_n;
    logic [NUM_CAT*VAL_W-1:0] param_bank, bank_n;
    logic [TO_W-1:0]          tmo_cnt, tmo_cnt_n;
    logic [TMP_W-1:0]         tmp;
    logic                     kev, busy_q, tmo_hit;

    assign kev    = key_event && kp.enable;
    assign busy_q = (state == SEL_CAT) || (state == ENTRY);

    always_comb begin
        state_n     = state;
        category_n  = category;
        entry_n     = entry_value;
        dcount_n    = digit_count;
        new_value_n = new_value;
        bank_n      = param_bank;
        update_n    = '0;
        updated_n   = 1'b0;
        error_n     = 1'b0;
        timeout_n   = 1'b0;
        tmp         = TMP_W'(entry_value) * TMP_W'(10) + TMP_W'(key_code);
        // A key event in the same cycle beats the timeout.
        tmo_hit     = (TIMEOUT_CYC != 0) && busy_q && !kev && (tmo_cnt == TO_W'(TO_LAST));

        if (tmo_hit) begin
            timeout_n = 1'b1;
            state_n   = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (kev && key_code == K_START) begin
                        state_n    = SEL_CAT;
                        category_n = '0;
                        entry_n    = '0;
                        dcount_n   = '0;
                    end
                end
                SEL_CAT: begin
                    if (kev) begin
                        if (key_code <= 4'd9) begin
                            if (key_code != 4'd0 && key_code <= 4'(NUM_CAT)) begin
                                category_n = key_code;
                                state_n    = ENTRY;
                            end else begin
                                error_n = 1'b1;
                            end
                        end else begin
                            case (key_code)
                                K_START: begin
                                    category_n = '0;
                                    entry_n    = '0;
                                    dcount_n   = '0;
                                end
                                K_BKSP, K_CANCEL: state_n = IDLE;
                                default: error_n = 1'b1;
                            endcase
                        end
                    end
                end
                ENTRY: begin
                    if (kev) begin
                        if (key_code <= 4'd9) begin
                            if (digit_count == 3'(MAX_DIGITS) || tmp > TMP_W'(MAX_VAL)) begin
                                error_n = 1'b1;
                            end else begin
                                entry_n  = tmp[VAL_W-1:0];
                                dcount_n = digit_count + 3'd1;
                            end
                        end else begin
                            case (key_code)
                                K_BKSP: begin
                                    if (digit_count != 3'd0) begin
                                        entry_n  = entry_value / VAL_W'(10);
                                        dcount_n = digit_count - 3'd1;
                                    end
                                end
                                K_ACCEPT: begin
                                    if (digit_count == 3'd0) error_n = 1'b1;
                                    else                     state_n = COMMIT;
                                end
                                K_CANCEL: state_n = IDLE;
                                K_START: begin
                                    state_n    = SEL_CAT;
                                    category_n = '0;
                                    entry_n    = '0;
                                    dcount_n   = '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                COMMIT: begin
                    for (int k = 0; k < NUM_CAT; k++) begin
                        if (category == 4'(k + 1)) begin
                            bank_n[k*VAL_W +: VAL_W] = entry_value;
                            update_n[k]              = 1'b1;
                        end
                    end
                    new_value_n = entry_value;
                    updated_n   = 1'b1;
                    state_n     = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        // Disabling still lets an in-flight COMMIT land; it only squashes the entry session.
        if (!kp.enable) begin
            state_n   = IDLE;
            error_n   = 1'b0;
            timeout_n = 1'b0;
        end

        tmo_cnt_n = (kev || state_n != state || !busy_q) ? '0 : tmo_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            category     <= '0;
            entry_value  <= '0;
            digit_count  <= '0;
            new_value    <= '0;
            update_pulse <= '0;
            updated      <= 1'b0;
            error        <= 1'b0;
            timeout      <= 1'b0;
            param_bank   <= INIT_VALS;
            tmo_cnt      <= '0;
        end else begin
            state        <= state_n;
            category     <= category_n;
            entry_value  <= entry_n;
            digit_count  <= dcount_n;
            new_value    <= new_value_n;
            update_pulse <= update_n;
            updated      <= updated_n;
            error        <= error_n;
            timeout      <= timeout_n;
            param_bank   <= bank_n;
            tmo_cnt      <= tmo_cnt_n;
        end
    end

    assign kp.busy         = busy_q;
    assign kp.category     = category;
    assign kp.entry_value  = entry_value;
    assign kp.digit_count  = digit_count;
    assign kp.new_value    = new_value;
    assign kp.update_pulse = update_pulse;
    assign kp.updated      = updated;
    assign kp.error        = error;
    assign kp.timeout      = timeout;
    assign kp.param_bank   = param_bank;
endmodule

// File: tb/tb_keypad_param_entry.sv
// Scoreboarded bench: stimulus queues expected commit/error/timeout pulses, a monitor pops them as the DUT emits them.
module tb_keypad_param_entry;
    localparam int K_START = 10, K_BKSP = 11, K_ACC = 12, K_CAN = 13, K_UNUSED = 14;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_param_entry_if #(.NUM_CAT(8), .VAL_W(10)) kif ();

    keypad_param_entry #(.TIMEOUT_CYC(50)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    typedef struct {
        logic [2:0]  kind;   // {updated, error, timeout}
        logic [3:0]  cat;
        logic [9:0]  val;
        logic [79:0] bank;
    } exp_t;

    exp_t        sb[$];
    logic [79:0] exp_bank;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_commit(input int cat, input int val);
        exp_t e;
        exp_bank[(cat-1)*10 +: 10] = 10'(val);
        e.kind = 3'b100; e.cat = 4'(cat); e.val = 10'(val); e.bank = exp_bank;
        sb.push_back(e);
    endtask

    task automatic push_flag(input logic [2:0] kind);
        exp_t e;
        e.kind = kind; e.cat = '0; e.val = '0; e.bank = '0;
        sb.push_back(e);
    endtask

    function automatic void key_rc(input int k, output logic [3:0] r, output logic [3:0] c);
        int ri, ci;
        logic [3:0] one;
        one = 4'b0001;
        ri = 3; ci = 3;
        if (k >= 1 && k <= 9) begin
            ri = (k - 1) / 3;
            ci = (k - 1) % 3;
        end else begin
            case (k)
                0:        begin ri = 3; ci = 0; end
                K_START:  begin ri = 0; ci = 3; end
                K_BKSP:   begin ri = 1; ci = 3; end
                K_ACC:    begin ri = 3; ci = 1; end
                K_CAN:    begin ri = 3; ci = 2; end
                K_UNUSED: begin ri = 2; ci = 3; end
                default:  begin ri = 3; ci = 3; end
            endcase
        end
        r = ~(one << ri);
        c = ~(one << ci);
    endfunction

    task automatic press_raw(input logic [3:0] r, input logic [3:0] c, input int hold);
        @(negedge clk);
        kif.keypad_row = r;
        kif.keypad_col = c;
        repeat (hold) @(negedge clk);
        kif.keypad_row = 4'hF;
        kif.keypad_col = 4'hF;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input int k);
        logic [3:0] r, c;
        key_rc(k, r, c);
        press_raw(r, c, 4);
    endtask

    // Monitor: every pulse the DUT raises must match the oldest outstanding expectation.
    initial begin
        exp_t        e;
        logic [7:0]  exp_pulse;
        forever begin
            @(negedge clk);
            if (reset && (kif.updated || kif.error || kif.timeout)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {kif.updated, kif.error, kif.timeout}, 3'b000);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {kif.updated, kif.error, kif.timeout}, e.kind);
                    if (e.kind == 3'b100) begin
                        exp_pulse = '0;
                        exp_pulse[e.cat - 4'd1] = 1'b1;
                        chk("commit_update_pulse", kif.update_pulse, exp_pulse);
                        chk("commit_new_value", kif.new_value, e.val);
                        chk("commit_category", kif.category, e.cat);
                        chk("commit_param_bank", kif.param_bank, e.bank);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [3:0] r, c;
        reset = 1'b0;
        kif.enable = 1'b1;
        kif.keypad_row = 4'hF;
        kif.keypad_col = 4'hF;
        exp_bank = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", kif.busy, 0);
        chk("rst_category", kif.category, 0);
        chk("rst_entry_value", kif.entry_value, 0);
        chk("rst_digit_count", kif.digit_count, 0);
        chk("rst_new_value", kif.new_value, 0);
        chk("rst_pulses", {kif.update_pulse, kif.updated, kif.error, kif.timeout}, 0);
        chk("rst_param_bank", kif.param_bank, 0);
        reset = 1'b1;

        // START 2 7 BKSP 7 ACCEPT
        press(K_START);  chk("seq1_busy", kif.busy, 1);
        press(2);        chk("seq1_category", kif.category, 2);
        press(7);        chk("seq1_entry_7", kif.entry_value, 7);
                         chk("seq1_digits_1", kif.digit_count, 1);
        press(K_BKSP);   chk("seq1_bksp_entry", kif.entry_value, 0);
                         chk("seq1_bksp_digits", kif.digit_count, 0);
        press(7);
        push_commit(2, 7);
        press(K_ACC);
        chk("seq1_idle", kif.busy, 0);
        chk("seq1_cat_retained", kif.category, 2);

        // START 3 7 8 9 ACCEPT
        press(K_START); press(3); press(7); press(8); press(9);
        chk("seq2_entry", kif.entry_value, 789);
        chk("seq2_digits", kif.digit_count, 3);
        push_commit(3, 789);
        press(K_ACC);
        chk("seq2_bank", kif.param_bank, exp_bank);

        // 1024 overflows VAL_W=10
        press(K_START); press(1); press(1); press(0); press(2);
        chk("ovf_entry_before", kif.entry_value, 102);
        push_flag(3'b010);
        press(4);
        chk("ovf_entry_kept", kif.entry_value, 102);
        chk("ovf_digits_kept", kif.digit_count, 3);
        push_commit(1, 102);
        press(K_ACC);

        // Fifth digit rejected even though the value would fit
        press(K_START); press(5); press(0); press(0); press(0); press(1);
        chk("maxdig_entry", kif.entry_value, 1);
        chk("maxdig_digits", kif.digit_count, 4);
        push_flag(3'b010);
        press(1);
        chk("maxdig_entry_kept", kif.entry_value, 1);
        push_commit(5, 1);
        press(K_ACC);

        // ACCEPT with nothing entered
        press(K_START); press(4);
        push_flag(3'b010);
        press(K_ACC);
        chk("empty_accept_stays", kif.busy, 1);
        press(K_CAN);
        chk("empty_cancel_idle", kif.busy, 0);
        chk("empty_cancel_bank", kif.param_bank, exp_bank);

        // Bad category selections, unusable patterns while selecting
        press(K_START);
        push_flag(3'b010); press(9);
        chk("cat9_category", kif.category, 0);
        chk("cat9_busy", kif.busy, 1);
        push_flag(3'b010); press(0);
        push_flag(3'b010); press(K_ACC);
        press(K_UNUSED);
        chk("unused_no_event", kif.category, 0);
        press_raw(4'b1100, 4'b1110, 4);
        chk("two_rows_no_event", kif.category, 0);
        key_rc(3, r, c);
        press_raw(r, c, 1);
        chk("one_cycle_no_event", kif.category, 0);
        chk("still_selecting", kif.busy, 1);
        press(K_CAN);
        chk("cat_cancel_idle", kif.busy, 0);
        chk("cat_cancel_bank", kif.param_bank, exp_bank);

        // Timeout 50 cycles after the last digit
        press(K_START); press(6);
        push_flag(3'b001);
        key_rc(5, r, c);
        @(negedge clk);
        kif.keypad_row = r;
        kif.keypad_col = c;
        n = 0;
        while (kif.digit_count != 3'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_digit_seen", kif.digit_count, 1);
        kif.keypad_row = 4'hF;
        kif.keypad_col = 4'hF;
        n = 0;
        while (!kif.timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", n, 50);
        @(negedge clk);
        chk("tmo_idle", kif.busy, 0);
        chk("tmo_bank", kif.param_bank, exp_bank);

        // enable=0 aborts a session and blocks new ones
        press(K_START); press(7);
        chk("en_category", kif.category, 7);
        @(negedge clk);
        kif.enable = 1'b0;
        @(negedge clk);
        chk("en_forced_idle", kif.busy, 0);
        press(K_START);
        chk("en_ignores_keys", kif.busy, 0);
        kif.enable = 1'b1;

        // Asynchronous reset mid-entry
        press(K_START); press(2); press(5);
        chk("arst_pre_entry", kif.entry_value, 5);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", kif.busy, 0);
        chk("arst_category", kif.category, 0);
        chk("arst_entry", kif.entry_value, 0);
        chk("arst_digits", kif.digit_count, 0);
        chk("arst_new_value", kif.new_value, 0);
        chk("arst_bank", kif.param_bank, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", 80'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
